// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned reads to instruction memory and
// holds the returned word in a one-entry buffer, with redirect/flush support.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic [5:0]  opcode
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SQUASH} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] addr_q;
    logic        slot_free;
    logic [31:0] target;

    assign slot_free = !inst_valid || !stall;
    assign target    = redirect_pc & ~32'd3;
    assign opcode    = inst[31:26];

    // Outside FETCH the address of the outstanding request comes from addr_q.
    assign imem_addr = (state == FETCH) ? pc : addr_q;

    // NOTE: assign a default before the case so no path leaves imem_req unassigned and infers a latch.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            FETCH:       imem_req = slot_free && !redirect;
            WAIT, SQUASH: imem_req = 1'b1;
            default:     imem_req = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignments; a later assignment in the same cycle overrides the consume default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC & ~32'd3;
            addr_q     <= 32'd0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
            inst_valid <= 1'b0;
        end else begin
            if (inst_valid && !stall)
                inst_valid <= 1'b0;

            case (state)
                IDLE: state <= FETCH;

                FETCH: begin
                    if (redirect) begin
                        pc         <= target;
                        inst_valid <= 1'b0;
                    end else if (imem_req) begin
                        addr_q <= pc;
                        if (imem_ack) begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + 32'd4;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (redirect) begin
                        pc         <= target;
                        inst_valid <= 1'b0;
                        state      <= imem_ack ? FETCH : SQUASH;
                    end else if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_pc    <= addr_q;
                        inst_valid <= 1'b1;
                        pc         <= addr_q + 32'd4;
                        state      <= FETCH;
                    end
                end

                SQUASH: begin
                    // The in-flight word belongs to a flushed path and is dropped on ack.
                    inst_valid <= 1'b0;
                    if (redirect)
                        pc <= target;
                    if (imem_ack)
                        state <= FETCH;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h00000000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned read address; bits [1:0] always 0.
REQ-006 imem_ack  input  1  memory accepts request and returns imem_rdata in the same cycle.
REQ-007 imem_rdata  input  32  instruction word; valid only when imem_req=1 and imem_ack=1.
REQ-008 stall  input  1  downstream cannot consume the held instruction this cycle.
REQ-009 redirect  input  1  one-cycle pulse: branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  target address; bits [1:0] ignored and treated as 0.
REQ-011 inst  output  32  held instruction word.
REQ-012 inst_pc  output  32  address from which inst was fetched.
REQ-013 inst_valid  output  1  inst/inst_pc hold an unconsumed instruction.
REQ-014 opcode  output  6  inst[31:26], combinational, drives the main control decoder.

Function
REQ-015 Registers: pc (next fetch address), imem_addr (address of the outstanding request), one-entry output buffer (inst, inst_pc, inst_valid), state.
REQ-016 States: IDLE, FETCH, WAIT, SQUASH.
REQ-017 Consume: the held instruction is consumed on any cycle with inst_valid=1 and stall=0; inst_valid clears at that edge unless a new instruction is captured.
REQ-018 slot_free = !inst_valid | (inst_valid & !stall).
REQ-019 IDLE: imem_req=0; next state FETCH unconditionally.
REQ-020 FETCH: imem_req = slot_free & !redirect; imem_addr = pc.
REQ-021 FETCH, imem_req=1, imem_ack=1: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, remain FETCH.
REQ-022 FETCH, imem_req=1, imem_ack=0: imem_addr register holds pc; next state WAIT.
REQ-023 WAIT: imem_req=1, imem_addr held stable until ack; the output slot is guaranteed empty at ack.
REQ-024 WAIT, imem_ack=1, no redirect: capture as in REQ-021 using the held address; next state FETCH.
REQ-025 Redirect in FETCH: pc<=redirect_pc&~3, inst_valid<=0, no request issued that cycle; remain FETCH.
REQ-026 Redirect in WAIT without ack: pc<=redirect_pc&~3, inst_valid<=0; next state SQUASH.
REQ-027 Redirect in WAIT with ack: returned word discarded, pc<=redirect_pc&~3, inst_valid<=0; next state FETCH.
REQ-028 SQUASH: imem_req=1, imem_addr held; on ack the word is discarded and the next state is FETCH; inst_valid stays 0.
REQ-029 Redirect in SQUASH: pc updated to the new target; remain SQUASH until ack.
REQ-030 Redirect has priority over capture and over consume in the same cycle.
REQ-031 pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-032 Throughput: with imem_ack=1 in the request cycle and stall=0, one instruction per cycle.
REQ-033 stall never alters an outstanding request; imem_req is never dropped before ack once asserted.

Reset
REQ-034 While rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, imem_addr=0, imem_req=0, inst=0, inst_pc=0, inst_valid=0, opcode=0.
REQ-035 Reset asserted mid-request abandons the request; after release, fetching restarts at RESET_PC.
REQ-036 First request issued in the second cycle after rst_n deasserts (IDLE, then FETCH).

Verification
REQ-037 Reset release, memory always acks, stall=0 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; inst_valid=1 from the cycle after the first request; inst_pc tracks.
REQ-038 inst 0x8C020004 held with stall=1 for 3 cycles -> inst, inst_pc, opcode=6'b100011 constant; imem_req=0; fetch resumes the cycle stall drops.
REQ-039 Request to 0x10 with imem_ack=0 for 4 cycles -> imem_req=1 and imem_addr=0x10 stable throughout; capture on the ack cycle.
REQ-040 Redirect to 0x41 while request to 0x20 is waiting -> SQUASH; 0x20 data discarded on ack; next request to 0x40; inst_valid=0 until 0x40 data returns.
REQ-041 redirect and imem_ack in the same FETCH-stage cycle -> word dropped, inst_valid=0 next cycle, next imem_addr=redirect target.
REQ-042 RESET_PC=32'hFFFFFFFC, continuous ack -> addresses 0xFFFFFFFC then 0x00000000.
